// File: rtl/note_pkg.sv
// Shared constants for the note tone path: octave-3 divisor table, note codes
// and the detector state encoding.
package note_pkg;

    localparam int NOTE_W     = 4;
    localparam int NUM_NOTES  = 12;
    localparam int NOTE_CNT_W = 28;

    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd15;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_MEASURE,
        ST_CLASSIFY,
        ST_REPORT
    } det_state_e;

    // Same 50 MHz divisors the tone generators use, C3 .. B3.
    function automatic logic [31:0] note_div(input logic [NOTE_W-1:0] idx);
        case (idx)
            4'd0:    return 32'd382234;
            4'd1:    return 32'd360776;
            4'd2:    return 32'd340530;
            4'd3:    return 32'd321419;
            4'd4:    return 32'd303379;
            4'd5:    return 32'd286352;
            4'd6:    return 32'd270270;
            4'd7:    return 32'd255102;
            4'd8:    return 32'd240790;
            4'd9:    return 32'd227273;
            4'd10:   return 32'd214517;
            4'd11:   return 32'd202478;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// registered rising-edge detector; the pulse lands 3 clocks after the input rises.
module tone_edge_sync (
    input  logic clock_in,
    input  logic reset_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync_p0, sync_p1, dly_p2;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            dly_p2     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_p0    <= async_in;
            sync_p1    <= sync_p0;
            dly_p2     <= sync_p1;
            rise_pulse <= sync_p1 & ~dly_p2;
        end
    end

endmodule

// File: rtl/note_detector.sv
// Measures the period of an incoming square-wave tone and classifies it as one
// of the 12 octave-3 semitones, with lock and silence tracking.
module note_detector
    import note_pkg::*;
#(
    parameter int CNT_W      = NOTE_CNT_W,
    parameter int TOL_SHIFT  = 6,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 1000000,
    parameter int MIN_PERIOD = 16,
    parameter int DIV_SHIFT  = 0   // scales the divisor table for prescaled tones
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              tone_in,
    output logic [NOTE_W-1:0] note_code,
    output logic [CNT_W-1:0]  period_out,
    output logic              note_strobe,
    output logic              locked,
    output logic              silent
);

    localparam int DIFF_W = CNT_W + 1;
    localparam int LOCK_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [NOTE_W-1:0] LAST_IDX = NOTE_W'(NUM_NOTES - 1);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LOCK_W-1:0] sat_inc_lock(input logic [LOCK_W-1:0] v);
        return (v >= LOCK_W'(LOCK_COUNT)) ? v : v + 1'b1;
    endfunction

    // Signed difference one bit wider than the counter so nothing wraps.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
        logic signed [DIFF_W-1:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? DIFF_W'(-d) : DIFF_W'(d);
    endfunction

    det_state_e state_q, state_d;

    logic              edge_pulse;
    logic [CNT_W-1:0]  cnt_q;
    logic [NOTE_W-1:0] idx_q, match_q, prev_code_q, final_code;
    logic              found_q;
    logic [LOCK_W-1:0] lock_cnt_q, lock_next;
    logic [CNT_W-1:0]  div_c, tol_c, period_c;
    logic              hit_c, timeout_c;

    tone_edge_sync u_sync (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .async_in  (tone_in),
        .rise_pulse(edge_pulse)
    );

    assign period_c  = sat_inc_cnt(cnt_q);
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign div_c     = CNT_W'(note_div(idx_q) >> DIV_SHIFT);
    assign tol_c     = div_c >> TOL_SHIFT;
    assign hit_c     = abs_diff(period_out, div_c) <= {1'b0, tol_c};

    // The last table entry is folded in here so the strobe leaves on the idx-11 cycle.
    always_comb begin
        final_code = NOTE_NONE;
        if (period_out >= CNT_W'(MIN_PERIOD)) begin
            if (found_q)    final_code = match_q;
            else if (hit_c) final_code = idx_q;
        end
        if (final_code != NOTE_NONE && final_code == prev_code_q)
            lock_next = sat_inc_lock(lock_cnt_q);
        else
            lock_next = (final_code != NOTE_NONE) ? LOCK_W'(1) : '0;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state_q <= ST_ARM;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM:      if (edge_pulse) state_d = ST_MEASURE;
            ST_MEASURE:  if (edge_pulse) state_d = ST_CLASSIFY;
                         else if (timeout_c) state_d = ST_ARM;
            ST_CLASSIFY: if (edge_pulse) state_d = ST_CLASSIFY;
                         else if (idx_q == LAST_IDX) state_d = ST_REPORT;
            ST_REPORT:   state_d = edge_pulse ? ST_CLASSIFY : ST_MEASURE;
            default:     state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            match_q     <= '0;
            found_q     <= 1'b0;
            prev_code_q <= NOTE_NONE;
            lock_cnt_q  <= '0;
            note_code   <= NOTE_NONE;
            period_out  <= '0;
            note_strobe <= 1'b0;
            locked      <= 1'b0;
            silent      <= 1'b1;
        end else begin
            cnt_q       <= edge_pulse ? '0 : sat_inc_cnt(cnt_q);
            note_strobe <= 1'b0;
            case (state_q)
                ST_ARM: if (edge_pulse) silent <= 1'b0;
                ST_MEASURE, ST_REPORT: if (edge_pulse) begin
                    period_out <= period_c;
                    idx_q      <= '0;
                    found_q    <= 1'b0;
                end
                ST_CLASSIFY: begin
                    if (edge_pulse) begin
                        // A new edge mid-search restarts on the fresh period.
                        period_out <= period_c;
                        idx_q      <= '0;
                        found_q    <= 1'b0;
                        lock_cnt_q <= '0;
                        locked     <= 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        note_code   <= final_code;
                        note_strobe <= 1'b1;
                        prev_code_q <= final_code;
                        lock_cnt_q  <= lock_next;
                        locked      <= (lock_next >= LOCK_W'(LOCK_COUNT));
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (!found_q && hit_c) begin
                            found_q <= 1'b1;
                            match_q <= idx_q;
                        end
                    end
                end
                default: ;
            endcase
            if (timeout_c && !edge_pulse && (state_q == ST_ARM || state_q == ST_MEASURE)) begin
                silent      <= 1'b1;
                note_code   <= NOTE_NONE;
                locked      <= 1'b0;
                lock_cnt_q  <= '0;
                prev_code_q <= NOTE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Scoreboard bench for note_detector with a prescaled divisor table so every
// note fits in a short run.
module tb_note_detector;

    localparam int CNT_W      = 28;
    localparam int TOL_SHIFT  = 6;
    localparam int LOCK_COUNT = 3;
    localparam int TIMEOUT    = 4000;
    localparam int MIN_PERIOD = 16;
    localparam int DIV_SHIFT  = 8;
    localparam int RISE_TO_STROBE = 16;  // 3 sync cycles + 13 edge-to-strobe

    logic             clock_in = 1'b0;
    logic             reset_n  = 1'b0;
    logic             tone_in  = 1'b0;
    logic [3:0]       note_code;
    logic [CNT_W-1:0] period_out;
    logic             note_strobe, locked, silent;

    note_detector #(
        .CNT_W(CNT_W), .TOL_SHIFT(TOL_SHIFT), .LOCK_COUNT(LOCK_COUNT),
        .TIMEOUT(TIMEOUT), .MIN_PERIOD(MIN_PERIOD), .DIV_SHIFT(DIV_SHIFT)
    ) dut (
        .clock_in(clock_in), .reset_n(reset_n), .tone_in(tone_in),
        .note_code(note_code), .period_out(period_out), .note_strobe(note_strobe),
        .locked(locked), .silent(silent)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int code;
        int period;
        int lk;
        int cyc;
        int prev_before;
    } exp_t;

    exp_t sb[$];

    int divs [12] = '{382234, 360776, 340530, 321419, 303379, 286352,
                      270270, 255102, 240790, 227273, 214517, 202478};

    function automatic int div_of(input int i);
        return divs[i] >> DIV_SHIFT;
    endfunction

    function automatic int classify(input int p);
        if (p < MIN_PERIOD) return 15;
        for (int i = 0; i < 12; i++) begin
            int d, diff;
            d    = div_of(i);
            diff = (p > d) ? p - d : d - p;
            if (diff <= (d >> TOL_SHIFT)) return i;
        end
        return 15;
    endfunction

    bit armed = 0;
    bit last_pushed = 0;
    int last_rise = 0;
    int lk_cnt = 0;
    int prev_code = 15;

    task automatic on_rise();
        int iv, code;
        exp_t e;
        iv = cyc - last_rise;
        if (armed && iv >= TIMEOUT) begin
            armed = 0; lk_cnt = 0; prev_code = 15;
        end
        if (!armed) begin
            armed = 1;
            last_pushed = 0;
        end else begin
            if (last_pushed && iv <= 12 && sb.size() > 0) begin
                e = sb.pop_back();
                prev_code = e.prev_before;
                lk_cnt = 0;
            end
            code = classify(iv);
            e.prev_before = prev_code;
            if (code != 15 && code == prev_code)
                lk_cnt = (lk_cnt < LOCK_COUNT) ? lk_cnt + 1 : lk_cnt;
            else
                lk_cnt = (code != 15) ? 1 : 0;
            prev_code = code;
            e.code   = code;
            e.period = iv;
            e.lk     = (lk_cnt >= LOCK_COUNT) ? 1 : 0;
            e.cyc    = cyc + RISE_TO_STROBE;
            sb.push_back(e);
            last_pushed = 1;
        end
        last_rise = cyc;
    endtask

    // Called at #1 after a posedge; returns at #1 after a posedge.
    task automatic tone(input int period, input int n);
        int h;
        h = period / 2;
        for (int k = 0; k < n; k++) begin
            tone_in = 1'b1;
            on_rise();
            repeat (h) @(posedge clock_in);
            #1 tone_in = 1'b0;
            repeat (period - h) @(posedge clock_in);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    always @(negedge clock_in) begin : monitor
        exp_t e;
        if (reset_n && note_strobe) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", note_strobe, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_code", note_code, e.code);
                chk("sb_period", period_out, e.period);
                chk("sb_locked", locked, e.lk);
                chk("strobe_latency", cyc, e.cyc);
            end
        end
    end

    always @(posedge clock_in) begin
        if (cyc > 90000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 90000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        int target;
        reset_n = 1'b0;
        tone_in = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
        chk("rst_code", note_code, 15);
        chk("rst_period", period_out, 0);
        chk("rst_strobe", note_strobe, 0);
        chk("rst_locked", locked, 0);
        chk("rst_silent", silent, 1);
        reset_n = 1'b1;
        idle(2);

        // F#3: first rise arms, locks on the third strobe
        tone(div_of(6), 5);
        chk("armed_silent", silent, 0);

        // A3 offset by +3000 (scaled), then an off-table period drops lock
        tone(div_of(9) + (3000 >> DIV_SHIFT), 4);
        tone(976, 1);
        tone(div_of(6), 4);

        // silence: tone held low after a locked F#3
        target = last_rise + 3 + TIMEOUT;
        while (cyc < target) @(negedge clock_in);
        chk("silent_early", silent, 0);
        @(negedge clock_in);
        chk("silent_set", silent, 1);
        chk("silent_code", note_code, 15);
        chk("silent_locked", locked, 0);
        @(posedge clock_in);
        #1;

        // glitch train with period 10: aborts until the train stops
        tone(10, 6);
        idle(100);
        tone(div_of(3), 4);

        // reset mid-classification, 5 cycles after the edge pulse
        tone_in = 1'b1;
        repeat (8) @(posedge clock_in);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_code", note_code, 15);
        chk("mid_rst_period", period_out, 0);
        chk("mid_rst_strobe", note_strobe, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_silent", silent, 1);
        tone_in = 1'b0;
        sb.delete();
        armed = 0; lk_cnt = 0; prev_code = 15; last_pushed = 0;
        repeat (3) @(posedge clock_in);
        #1 reset_n = 1'b1;
        idle(20);

        // sweep every divisor
        tone(div_of(0), 3);
        for (int i = 0; i < 12; i++) tone(div_of(i), 2);
        idle(40);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_detector.md
Name: note_detector

Overview:
- Receive-side counterpart of the note tone generators: measures the period of an incoming square-wave tone and classifies it as one of the 12 semitones of octave 3.
- Tone generators produce the square wave by dividing a 50 MHz `clock_in`; this block checks the resulting tone in loopback and on the audio test header.
- Outputs a note code, the raw period, a per-period strobe, a lock flag and a silence flag.

Parameters:
- CNT_W, default 28: period counter width.
- TOL_SHIFT, default 6: match tolerance is a window of ±(div >> TOL_SHIFT), about 1.6 %.
- LOCK_COUNT, default 3: consecutive identical matches required to assert `locked`.
- TIMEOUT, default 1000000: cycles without a rising edge before `silent` asserts (20 ms).
- MIN_PERIOD, default 16: periods shorter than this are glitches and are never matched.

Ports:
- clock_in, input, 1: 50 MHz system clock.
- reset_n, input, 1: asynchronous active-low reset.
- tone_in, input, 1: asynchronous square-wave tone.
- note_code, output, 4: matched note, 0=C … 6=F# … 11=B; 15 = none.
- period_out, output, CNT_W: last measured period in `clock_in` cycles.
- note_strobe, output, 1: one-cycle pulse when `note_code`/`period_out` update.
- locked, output, 1: the same note has matched LOCK_COUNT consecutive times.
- silent, output, 1: no rising edge for TIMEOUT cycles.

Behaviour:
- Reset values (async on `reset_n` low): `note_code` = 15, `period_out` = 0, `note_strobe` = 0, `locked` = 0, `silent` = 1. Counter cleared, FSM in ARM.
- Input path:
  - `tone_in` passes through a 2-FF synchronizer, then a delay register.
  - The rising-edge pulse `edge` is valid 3 cycles after the input transition.
- Period counter:
  - Increments every cycle and saturates at all-ones.
  - On `edge`, the counter value + 1 is the period. The counter reloads to 0.
- FSM states:
  - ARM: wait for the first edge after reset or silence. On `edge`, clear `silent` and go to MEASURE. No strobe is produced.
  - MEASURE: on `edge`, latch the period into `period_out` and go to CLASSIFY with idx = 0.
  - CLASSIFY:
    - One table entry per cycle, idx 0..11.
    - Entry idx matches if |P − NOTE_DIV[idx]| ≤ NOTE_DIV[idx] >> TOL_SHIFT. The first match wins.
    - After idx 11, go to REPORT.
  - REPORT (1 cycle):
    - Drive `note_code` (15 if no match, or if P < MIN_PERIOD) and pulse `note_strobe`, then return to MEASURE.
    - The strobe occurs exactly 13 cycles after the `edge` cycle.
- Lock logic, evaluated at REPORT:
  - If the code equals the previous code and is not 15, increment the match count (saturating). Otherwise, set the count to 1 on a match or 0 on no match.
  - `locked` = (count ≥ LOCK_COUNT). It is updated in the same cycle as `note_strobe`.
- Edge during CLASSIFY:
  - The current classification is aborted; no strobe is issued.
  - The new period is latched, idx restarts at 0, and the lock count clears.
- Silence:
  - If the counter reaches TIMEOUT in MEASURE or ARM: `silent` = 1, `note_code` = 15, `locked` = 0, lock count = 0, go to ARM.
  - The next edge re-arms without reporting, because the period spanning silence is invalid.
- Arithmetic:
  - Compute |difference| at CNT_W+1 bits signed or by compare-then-subtract; no wrap is allowed.
  - The tolerance is a right shift of the constant and can be precomputed in the package.
- `reset_n` asserted mid-CLASSIFY: all state returns to reset values immediately; no partial strobe.

Decomposition:
- Package `note_pkg`:
  - NOTE_DIV[0..11] = 382234, 360776, 340530, 321419, 303379, 286352, 270270, 255102, 240790, 227273, 214517, 202478.
  - NOTE_NONE = 4'd15; NOTE_W = 4; CNT_W default.
  - These are the same divisors used by the tone generators.
- Sub-module `tone_edge_sync`: 2-FF synchronizer plus rising-edge detector, with async active-low reset. It is reused by later input blocks.

Test Plan:
- F#3: tone period 270270, 5 periods → first strobe after the 2nd edge, `note_code` = 6, `period_out` = 270270. `locked` = 1 at the 3rd strobe.
- A3 with offset: period 227273 + 3000 (tolerance 3551) → `note_code` = 9. Then period 250000 → `note_code` = 15, `locked` drops to 0 on that strobe.
- Silence: F#3 locked, then `tone_in` held low → `silent` = 1 exactly TIMEOUT cycles after the last edge counter reload, `note_code` = 15, `locked` = 0. The next edge produces no strobe.
- Glitch: two edges 10 cycles apart after arming → CLASSIFY aborted, no strobe. A pulse train with period 10 → `note_code` = 15.
- Reset mid-CLASSIFY: drop `reset_n` 5 cycles after an edge → all outputs at reset values asynchronously, `silent` = 1, no strobe after release until two edges.
- Sweep: loop each tone generator divisor 0..11 into `tone_in` → `note_code` equals idx for every note. Check strobe latency of 13 cycles from `edge`.
